// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised synchronous up/down modulo counter with
// parallel load, direction control and a one-shot IDLE/RUN/DONE control FSM.
// Define MOD_UPDOWN_COUNTER_GRAY_EN to add the registered Gray-code output q_gray.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             done
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Top of the count range, and the modulus widened by one bit so that
  // MODULUS == 2**WIDTH still compares correctly against a WIDTH-bit value.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;
  logic             r_wrap;
  logic             r_done;
  logic             r_busy;

  logic             w_tc;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_cnt_val;
  logic             w_arm;
  logic             w_count_en;
  logic             w_run_end;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;

  // Terminal count depends on the current direction: top when counting up,
  // zero when counting down.
  always_comb begin
    w_tc = 1'b0;
    if (up_down) begin
      w_tc = (r_q == MAX_VAL);
    end else begin
      w_tc = (r_q == '0);
    end
  end

  // Out-of-range load values saturate at the top of the count range.
  always_comb begin
    w_load_val = load_value;
    if ({1'b0, load_value} >= MOD_EXT) begin
      w_load_val = MAX_VAL;
    end
  end

  // Modulo increment/decrement; the terminal value folds back to the other end.
  always_comb begin
    w_cnt_val = r_q;
    if (up_down) begin
      w_cnt_val = w_tc ? '0 : r_q + 1'b1;
    end else begin
      w_cnt_val = w_tc ? MAX_VAL : r_q - 1'b1;
    end
  end

  // Decide whether this edge counts. The arming edge in IDLE does not count,
  // RUN stops (instead of wrapping) at terminal count, and DONE always holds.
  // Load has priority over counting in every state.
  always_comb begin
    w_arm      = (r_state == S_IDLE) && start && oneshot;
    w_run_end  = (r_state == S_RUN) && enable && !load && w_tc;
    w_count_en = 1'b0;
    if (enable && !load) begin
      case (r_state)
        S_IDLE:  w_count_en = !w_arm;
        S_RUN:   w_count_en = !w_tc;
        default: w_count_en = 1'b0;
      endcase
    end
  end

  // Next counter value and wrap flag. A wrap can only come from a counting
  // edge at terminal count, which in practice means free-run in IDLE.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_q_nxt = w_load_val;
    end else if (w_count_en) begin
      w_q_nxt    = w_cnt_val;
      w_wrap_nxt = w_tc;
    end
  end

  // Counter value, its complement and the wrap pulse, all registered together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_qb   <= '1;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_qb   <= ~w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // One-shot control FSM with registered busy/done outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arm) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_run_end) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [WIDTH-1:0] r_q_gray;

  // Gray code tracks q on the same edge, derived from the next count value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q_gray <= '0;
    end else begin
      r_q_gray <= w_q_nxt ^ (w_q_nxt >> 1);
    end
  end

  assign q_gray = r_q_gray;
`endif

  assign q    = r_q;
  assign qb   = r_qb;
  assign tc   = w_tc;
  assign wrap = r_wrap;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed testbench for mod_updown_counter (WIDTH=4, MODULUS=10); with
// MOD_UPDOWN_COUNTER_GRAY_EN a second MODULUS=16 instance checks q_gray.
module tb_mod_updown_counter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_value;
  logic       oneshot;
  logic       start;
  logic [3:0] q;
  logic [3:0] qb;
  logic       tc;
  logic       wrap;
  logic       busy;
  logic       done;

  int ntests = 0;
  int nfail  = 0;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .oneshot    (oneshot),
    .start      (start),
    .q          (q),
    .qb         (qb),
    .tc         (tc),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    ,
    .q_gray     ()
`endif
  );

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  logic [3:0] g_q, g_qb, g_gray;
  logic       g_tc, g_wrap, g_busy, g_done;

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .oneshot    (oneshot),
    .start      (start),
    .q          (g_q),
    .qb         (g_qb),
    .tc         (g_tc),
    .wrap       (g_wrap),
    .busy       (g_busy),
    .done       (g_done),
    .q_gray     (g_gray)
  );
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = 4'd0; oneshot = 1'b0; start = 1'b0;
    #2;
    ntests++;
    if (q !== 4'd0 || qb !== 4'hF || wrap !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL reset_init: q=%0d qb=%h wrap=%b busy=%b done=%b want q=0 qb=f 0 0 0",
               q, qb, wrap, busy, done);
    end
    tick(); tick();
    reset = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    ntests++;
    if (q !== 4'd7) begin
      nfail++;
      $display("FAIL reset_precount: q=%0d want 7", q);
    end
    reset = 1'b1;
    enable = 1'b0;
    #1;
    ntests++;
    if (q !== 4'd0 || qb !== 4'hF || wrap !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_async: q=%0d qb=%h wrap=%b busy=%b want q=0 qb=f 0 0",
               q, qb, wrap, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    int eq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int ew[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int et[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      ntests++;
      if (q !== 4'(eq[i]) || qb !== 4'(15 - eq[i]) || wrap !== 1'(ew[i]) || tc !== 1'(et[i])) begin
        nfail++;
        $display("FAIL count_up[%0d]: q=%0d qb=%h wrap=%b tc=%b want q=%0d qb=%h wrap=%0d tc=%0d",
                 i, q, qb, wrap, tc, eq[i], 4'(15 - eq[i]), ew[i], et[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_count_down();
    int eq[4] = '{1, 0, 9, 8};
    int ew[4] = '{0, 0, 1, 0};
    int et[4] = '{0, 1, 0, 0};
    enable = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ntests++;
      if (q !== 4'(eq[i]) || qb !== 4'(15 - eq[i]) || wrap !== 1'(ew[i]) || tc !== 1'(et[i])) begin
        nfail++;
        $display("FAIL count_down[%0d]: q=%0d qb=%h wrap=%b tc=%b want q=%0d wrap=%0d tc=%0d",
                 i, q, qb, wrap, tc, eq[i], ew[i], et[i]);
      end
    end
    enable = 1'b0; up_down = 1'b1;
  endtask

  task automatic test_load();
    int lv[4] = '{13, 4, 10, 15};
    int le[4] = '{1, 1, 1, 1};
    int eq[4] = '{9, 4, 9, 9};
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; load_value = 4'(lv[i]); enable = 1'(le[i]);
      if (i == 0) enable = 1'b0;
      tick();
      ntests++;
      if (q !== 4'(eq[i]) || qb !== 4'(15 - eq[i]) || wrap !== 1'b0 || busy !== 1'b0) begin
        nfail++;
        $display("FAIL load[%0d]: q=%0d qb=%h wrap=%b busy=%b want q=%0d wrap=0 busy=0",
                 i, q, qb, wrap, busy, eq[i]);
      end
    end
    load = 1'b0; enable = 1'b1;
    tick();
    ntests++;
    if (q !== 4'd0 || wrap !== 1'b1) begin
      nfail++;
      $display("FAIL load_then_count: q=%0d wrap=%b want q=0 wrap=1", q, wrap);
    end
    enable = 1'b0;
  endtask

  task automatic test_oneshot();
    // start with oneshot=0 is ignored: plain free-run count
    enable = 1'b1; up_down = 1'b1; start = 1'b1; oneshot = 1'b0;
    tick();
    start = 1'b0;
    ntests++;
    if (q !== 4'd1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL start_freerun: q=%0d busy=%b want q=1 busy=0", q, busy);
    end
    enable = 1'b0; load = 1'b1; load_value = 4'd6;
    tick();
    load = 1'b0;
    // arming edge: no count
    enable = 1'b1; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    ntests++;
    if (q !== 4'd6 || busy !== 1'b1 || wrap !== 1'b0) begin
      nfail++;
      $display("FAIL oneshot_arm: q=%0d busy=%b wrap=%b want q=6 busy=1 wrap=0", q, busy, wrap);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin start = 1'b1; oneshot = 1'b1; end
      tick();
      start = 1'b0; oneshot = 1'b0;
      ntests++;
      if (q !== 4'(7 + i) || busy !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
        nfail++;
        $display("FAIL oneshot_run[%0d]: q=%0d busy=%b done=%b wrap=%b want q=%0d busy=1 done=0 wrap=0",
                 i, q, busy, done, wrap, 7 + i);
      end
    end
    tick();
    ntests++;
    if (q !== 4'd9 || done !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0) begin
      nfail++;
      $display("FAIL oneshot_done: q=%0d done=%b busy=%b wrap=%b want q=9 done=1 busy=0 wrap=0",
               q, done, busy, wrap);
    end
    start = 1'b1; oneshot = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    ntests++;
    if (q !== 4'd9 || done !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL oneshot_after: q=%0d done=%b busy=%b want q=9 done=0 busy=0", q, done, busy);
    end
    tick();
    ntests++;
    if (q !== 4'd0 || wrap !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL oneshot_idle: q=%0d wrap=%b busy=%b want q=0 wrap=1 busy=0", q, wrap, busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_load_at_tc();
    load = 1'b1; load_value = 4'd8; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    tick();
    ntests++;
    if (q !== 4'd9 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL ltc_reach: q=%0d busy=%b want q=9 busy=1", q, busy);
    end
    enable = 1'b0;
    tick();
    ntests++;
    if (q !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      nfail++;
      $display("FAIL ltc_freeze: q=%0d busy=%b done=%b want q=9 busy=1 done=0", q, busy, done);
    end
    enable = 1'b1; load = 1'b1; load_value = 4'd3;
    tick();
    load = 1'b0;
    ntests++;
    if (q !== 4'd3 || busy !== 1'b1 || done !== 1'b0) begin
      nfail++;
      $display("FAIL ltc_load_wins: q=%0d busy=%b done=%b want q=3 busy=1 done=0", q, busy, done);
    end
    for (int i = 0; i < 6; i++) tick();
    ntests++;
    if (q !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      nfail++;
      $display("FAIL ltc_rerun: q=%0d busy=%b done=%b want q=9 busy=1 done=0", q, busy, done);
    end
    tick();
    ntests++;
    if (q !== 4'd9 || busy !== 1'b0 || done !== 1'b1) begin
      nfail++;
      $display("FAIL ltc_done: q=%0d busy=%b done=%b want q=9 busy=0 done=1", q, busy, done);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_run();
    load = 1'b1; load_value = 4'd6; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; oneshot = 1'b0;
    tick(); tick();
    ntests++;
    if (q !== 4'd8 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL rrun_pre: q=%0d busy=%b want q=8 busy=1", q, busy);
    end
    reset = 1'b1;
    #1;
    ntests++;
    if (q !== 4'd0 || qb !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
      nfail++;
      $display("FAIL rrun_reset: q=%0d qb=%h busy=%b done=%b want q=0 qb=f busy=0 done=0",
               q, qb, busy, done);
    end
    reset = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      ntests++;
      if (q !== 4'(i) || busy !== 1'b0 || done !== 1'b0) begin
        nfail++;
        $display("FAIL rrun_idle[%0d]: q=%0d busy=%b done=%b want q=%0d busy=0 done=0",
                 i, q, busy, done, i);
      end
    end
    enable = 1'b0;
  endtask

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
  task automatic test_gray();
    logic [3:0] m;
    logic [3:0] prev;
    reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; start = 1'b0;
    #1;
    ntests++;
    if (g_gray !== 4'd0) begin
      nfail++;
      $display("FAIL gray_reset: q_gray=%h want 0", g_gray);
    end
    reset = 1'b0;
    m = 4'd0;
    prev = 4'd0;
    enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      m = m + 4'd1;
      ntests++;
      if (g_q !== m || g_gray !== (m ^ (m >> 1)) || $countones(g_gray ^ prev) != 1) begin
        nfail++;
        $display("FAIL gray[%0d]: q=%0d q_gray=%h prev=%h want q=%0d q_gray=%h one-bit step",
                 i, g_q, g_gray, prev, m, m ^ (m >> 1));
      end
      prev = g_gray;
    end
    enable = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_oneshot();
    test_load_at_tc();
    test_reset_in_run();
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    test_gray();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter: the next generation of the team's four-bit ripple counter.
- All bits share one clock, so there is no ripple skew.
- Adds a programmable modulus, a synchronous parallel load, direction control and a one-shot mode with a small control FSM.
- Used as a general event/timebase counter in datapath and lab designs; instantiated standalone or driven by higher-level controllers.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  count enable; when low, the counter holds.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value taken on load.
- oneshot  input  1  mode select, sampled on start: 1 = one-shot, 0 = free-run.
- start  input  1  one-cycle pulse that arms a one-shot run.
- q  output  WIDTH  counter value, registered.
- qb  output  WIDTH  bitwise complement of q, registered.
- tc  output  1  terminal count, combinational from q and up_down.
- wrap  output  1  one-cycle pulse, registered, on modulo wrap.
- busy  output  1  high while a one-shot run is active.
- done  output  1  one-cycle pulse, registered, at one-shot completion.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - On reset assertion, immediately: q=0, qb=all ones, wrap=0, done=0, FSM=IDLE, busy=0.
  - Reset mid-run aborts the run with no done pulse.
- Priority each posedge: load > count > hold.
- Load:
  - q <= load_value, clamped to MODULUS-1 when load_value >= MODULUS.
  - Takes effect the next cycle. No wrap/done pulse results from a load.
  - Load during RUN does not change FSM state.
- Terminal count:
  - tc = (q==MODULUS-1) when up_down=1.
  - tc = (q==0) when up_down=0.
- Count:
  - Up: q+1; at MODULUS-1 the next value is 0.
  - Down: q-1; at 0 the next value is MODULUS-1.
  - A wrap asserts wrap for exactly the following cycle.
  - Latency is 1 clock from an enabled edge to the new q.
- qb always equals ~q in the same cycle.
- Direction change takes effect on the next enabled edge. No glitch or skip.
- FSM states: IDLE, RUN, DONE.
  - IDLE: free-run counting whenever enable=1. Transition to RUN when start=1 and the sampled oneshot=1; in that case the same edge neither counts nor wraps. start with oneshot=0 is ignored.
  - RUN: busy=1. Counts while enable=1. On an enabled edge with tc=1, q holds (no wrap, wrap stays 0) and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, q holds; next state is IDLE regardless of inputs. start in DONE is ignored.
  - start while in RUN is ignored.
- Simultaneous load and terminal-count edge in RUN: load wins, the FSM stays in RUN, no done pulse.
- enable=0 freezes q and the FSM in RUN. IDLE/DONE transitions are unaffected.

Optional Feature:
- Macro: MOD_UPDOWN_COUNTER_GRAY_EN.
- When defined:
  - Adds output port q_gray (WIDTH): registered Gray code of q, i.e. q ^ (q>>1), updated in the same cycle as q.
  - Reset value 0.
  - Intended for safe clock-domain crossing of the count; valid Gray adjacency is guaranteed only when MODULUS is a power of two.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
- Reset with q=7 mid-count -> q=0 and qb=4'hF immediately, before the next edge; wrap=0, busy=0.
- enable=1, up_down=1 for 12 edges from 0 -> q runs 1..9,0,1,2; wrap high exactly one cycle after 9->0; tc high while q=9.
- up_down=0 from q=1 for 3 edges -> q runs 0,9,8; wrap pulses after 0->9; tc high while q=0.
- load=1, load_value=13 -> q=9 next cycle; load_value=4 with enable=1 -> q=4, load beats count.
- oneshot=1, start pulse at q=6, up -> busy=1, q counts 7,8,9 and holds at 9; done=1 for one cycle; busy=0 thereafter; no wrap.
- In RUN, assert reset at q=8 -> q=0 and FSM IDLE, no done. With MOD_UPDOWN_COUNTER_GRAY_EN and MODULUS=16, count 0..15 -> q_gray changes exactly one bit per edge, including at the 15->0 wrap.
